// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package alu_muldiv_pkg;

   // Operation codes, identical to the RV32M funct3 field.
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } muldiv_state_e;

   localparam int unsigned XLEN_DEFAULT = 32;

   // Width of the iteration counter, which runs XLEN-1 down to 0.
   function automatic int unsigned cnt_width(input int unsigned xlen);
      return (xlen < 2) ? 1 : $clog2(xlen);
   endfunction

   localparam int unsigned CNT_W_DEFAULT = cnt_width(XLEN_DEFAULT);

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation (result = enable ? -value : value).
module muldiv_negate #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   input  logic             enable,
   output logic [WIDTH-1:0] result
);

   // Negate modulo 2^WIDTH when enabled, otherwise pass through.
   always_comb begin
      result = enable ? ((~value) + WIDTH'(1)) : value;
   end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide,
// one bit per cycle, with START/BUSY/RESULT_VALID handshake and FLUSH.
// Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow
// and multiply-by-zero skip the iteration and complete one cycle after START.
module alu_muldiv_seq
   import alu_muldiv_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic            FLUSH,
   input  logic [2:0]      ALU_OPERATION,
   input  logic [XLEN-1:0] DATA1,
   input  logic [XLEN-1:0] DATA2,
   output logic            BUSY,
   output logic            RESULT_VALID,
   output logic [XLEN-1:0] RESULT
);

   localparam int unsigned CNT_W = cnt_width(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_e   state;
   muldiv_op_e      op_q;
   logic [XLEN-1:0] acc_hi;      // product high half / partial remainder
   logic [XLEN-1:0] acc_lo;      // multiplier / dividend, becomes low product / quotient
   logic [XLEN-1:0] opnd;        // multiplicand / divisor magnitude
   logic [CNT_W-1:0] count;
   logic            neg_q;
   logic            spec_q;
   logic [XLEN-1:0] spec_val_q;

   // Capture-side decode
   logic            is_div, is_rem, a_signed, b_signed, a_neg, b_neg, neg_in;
   logic            div_zero, div_ovf, mul_zero, spec_in;
   logic [XLEN-1:0] spec_val_in;
   logic [XLEN-1:0] mag_a, mag_b;

   // Iteration datapath
   logic [XLEN:0]   mul_sum, div_shift, div_diff;
   logic [XLEN-1:0] nxt_hi, nxt_lo;
   logic [2*XLEN-1:0] fix_in, fixed;
   logic [XLEN-1:0] calc_result;

   // Decode operand signedness and the fixed-result corner cases at capture.
   always_comb begin
      is_div   = ALU_OPERATION[2];
      is_rem   = ALU_OPERATION[2] & ALU_OPERATION[1];
      a_signed = (ALU_OPERATION == OP_MUL)    || (ALU_OPERATION == OP_MULH) ||
                 (ALU_OPERATION == OP_MULHSU) || (ALU_OPERATION == OP_DIV)  ||
                 (ALU_OPERATION == OP_REM);
      b_signed = (ALU_OPERATION == OP_MUL) || (ALU_OPERATION == OP_MULH) ||
                 (ALU_OPERATION == OP_DIV) || (ALU_OPERATION == OP_REM);
      a_neg    = a_signed & DATA1[XLEN-1];
      b_neg    = b_signed & DATA2[XLEN-1];
      neg_in   = is_rem ? a_neg : (a_neg ^ b_neg);
      div_zero = is_div & (DATA2 == '0);
      div_ovf  = is_div & ~ALU_OPERATION[0] & (DATA1 == MIN_NEG) & (DATA2 == '1);
      mul_zero = ~is_div & ((DATA1 == '0) | (DATA2 == '0));
      spec_in  = div_zero | div_ovf | mul_zero;
      if (div_zero) begin
         spec_val_in = is_rem ? DATA1 : '1;
      end else if (div_ovf) begin
         spec_val_in = is_rem ? '0 : MIN_NEG;
      end else begin
         spec_val_in = '0;
      end
   end

   muldiv_negate #(.WIDTH(XLEN)) u_neg_a (
      .value  (DATA1),
      .enable (a_neg),
      .result (mag_a)
   );

   muldiv_negate #(.WIDTH(XLEN)) u_neg_b (
      .value  (DATA2),
      .enable (b_neg),
      .result (mag_b)
   );

   // One shift-add or restoring-subtract step on the accumulator pair.
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      div_shift = {acc_hi, acc_lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd};
      if (!op_q[2]) begin
         nxt_hi = mul_sum[XLEN:1];
         nxt_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
      end else if (!div_diff[XLEN]) begin
         nxt_hi = div_diff[XLEN-1:0];
         nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
         nxt_hi = div_shift[XLEN-1:0];
         nxt_lo = {acc_lo[XLEN-2:0], 1'b0};
      end
   end

   // Sign fix-up works on the full 2*XLEN product so the high half borrows
   // correctly; a quotient or remainder is zero-extended into the low half.
   always_comb begin
      if (!op_q[2]) begin
         fix_in = {nxt_hi, nxt_lo};
      end else begin
         fix_in = {{XLEN{1'b0}}, (op_q[1] ? nxt_hi : nxt_lo)};
      end
   end

   muldiv_negate #(.WIDTH(2*XLEN)) u_neg_res (
      .value  (fix_in),
      .enable (neg_q),
      .result (fixed)
   );

   // Select the half of the fixed-up value the operation returns.
   always_comb begin
      calc_result = (!op_q[2] && (op_q != OP_MUL)) ? fixed[2*XLEN-1:XLEN]
                                                    : fixed[XLEN-1:0];
   end

   // Control FSM with registered BUSY/RESULT_VALID/RESULT.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= IDLE;
         BUSY         <= 1'b0;
         RESULT_VALID <= 1'b0;
         RESULT       <= '0;
         count        <= '0;
         op_q         <= OP_MUL;
         acc_hi       <= '0;
         acc_lo       <= '0;
         opnd         <= '0;
         neg_q        <= 1'b0;
         spec_q       <= 1'b0;
         spec_val_q   <= '0;
      end else if (FLUSH) begin
         state        <= IDLE;
         BUSY         <= 1'b0;
         RESULT_VALID <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               RESULT_VALID <= 1'b0;
               if (START) begin
                  op_q       <= muldiv_op_e'(ALU_OPERATION);
                  neg_q      <= neg_in;
                  spec_q     <= spec_in;
                  spec_val_q <= spec_val_in;
                  acc_hi     <= '0;
                  acc_lo     <= is_div ? mag_a : mag_b;
                  opnd       <= is_div ? mag_b : mag_a;
                  count      <= CNT_W'(XLEN - 1);
`ifdef MULDIV_EARLY_OUT_EN
                  if (spec_in) begin
                     state        <= DONE;
                     BUSY         <= 1'b0;
                     RESULT_VALID <= 1'b1;
                     RESULT       <= spec_val_in;
                  end else begin
                     state <= CALC;
                     BUSY  <= 1'b1;
                  end
`else
                  state <= CALC;
                  BUSY  <= 1'b1;
`endif
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               acc_hi <= nxt_hi;
               acc_lo <= nxt_lo;
               if (count == '0) begin
                  state        <= DONE;
                  BUSY         <= 1'b0;
                  RESULT_VALID <= 1'b1;
                  RESULT       <= spec_q ? spec_val_q : calc_result;
               end else begin
                  count <= count - CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule
